// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven up/down counter paced by a 2^N-cycle
// prescaler. A three-state FSM (IDLE/RUN/DONE) accepts START, STOP, LOAD and
// SETLIM commands. Each prescaler tick moves the count one step towards the
// limit. When the limit is reached, the counter either reloads from base or
// parks in DONE.
//
// Ports:
//   clk          system clock, all state changes on its rising edge
//   rst          synchronous active-high reset
//   cmd_valid    command offered
//   cmd_ready    command accepted (always 1 outside reset)
//   cmd_op       00 START, 01 STOP, 10 LOAD, 11 SETLIM
//   cmd_arg      operand for LOAD / SETLIM
//   up_dn        direction, latched on START (1 = up)
//   auto_reload  reload mode, latched on START
//   data         current count (registered)
//   tick         prescaler tick; the counter steps at the end of this cycle
//   running      registered copy of (state == RUN)
//   done         one-cycle pulse on terminal count
//   err          one-cycle pulse for a command that is illegal in RUN
module counter_sequencer #(
  parameter int N = 20,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_arg,
  input  logic         up_dn,
  input  logic         auto_reload,
  output logic [W-1:0] data,
  output logic         tick,
  output logic         running,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_STOP   = 2'b01;
  localparam logic [1:0] OP_LOAD   = 2'b10;
  localparam logic [1:0] OP_SETLIM = 2'b11;

  state_e         state_q, state_d;
  logic [N-1:0]   pre_q, pre_d;
  logic [W-1:0]   data_q, data_d;
  logic [W-1:0]   base_q, base_d;
  logic [W-1:0]   limit_q, limit_d;
  logic           dir_q, dir_d;
  logic           reload_q, reload_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           running_q, running_d;
  logic           cmd_acc;

  assign cmd_ready = ~rst;
  assign cmd_acc   = cmd_valid & cmd_ready;
  assign tick      = (state_q == S_RUN) && (&pre_q);

  assign data    = data_q;
  assign running = running_q;
  assign done    = done_q;
  assign err     = err_q;

  always_comb begin
    state_d  = state_q;
    pre_d    = '0;
    data_d   = data_q;
    base_d   = base_q;
    limit_d  = limit_q;
    dir_d    = dir_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if (state_q == S_RUN) begin
      if (cmd_acc && cmd_op == OP_STOP) begin
        // STOP beats a coincident tick: no step, no done
        state_d = S_IDLE;
      end else begin
        // Any other command in RUN is swallowed and flagged
        err_d = cmd_acc;
        pre_d = pre_q + 1'b1;
        if (tick) begin
          if (data_q == limit_q) begin
            done_d = 1'b1;
            if (reload_q) data_d  = base_q;
            else          state_d = S_DONE;
          end else if (dir_q) begin
            data_d = data_q + 1'b1;
          end else begin
            data_d = data_q - 1'b1;
          end
        end
      end
    end else if (cmd_acc) begin
      unique case (cmd_op)
        OP_START: begin
          // From IDLE the count resumes; from DONE it restarts at base
          if (state_q == S_DONE) data_d = base_q;
          state_d  = S_RUN;
          dir_d    = up_dn;
          reload_d = auto_reload;
        end
        OP_LOAD: begin
          base_d  = cmd_arg;
          data_d  = cmd_arg;
          state_d = S_IDLE;
        end
        OP_SETLIM: limit_d = cmd_arg;
        default: ;  // STOP outside RUN is a no-op
      endcase
    end

    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      data_q    <= '0;
      base_q    <= '0;
      limit_q   <= '1;
      dir_q     <= 1'b1;
      reload_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      data_q    <= data_d;
      base_q    <= base_d;
      limit_q   <= limit_d;
      dir_q     <= dir_d;
      reload_q  <= reload_d;
      done_q    <= done_d;
      err_q     <= err_d;
      running_q <= running_d;
    end
  end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter N, default 20: prescaler width; in RUN, the tick period is 2^N clk cycles.
REQ-002 Parameter W, default 4: counter data width.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-007 cmd_op  in  2  command: 00 START, 01 STOP, 10 LOAD, 11 SETLIM.
REQ-008 cmd_arg  in  W  operand for LOAD/SETLIM; ignored for START/STOP.
REQ-009 up_dn  in  1  direction, sampled only on accepted START: 1 = up, 0 = down.
REQ-010 auto_reload  in  1  reload mode, sampled only on accepted START.
REQ-011 data  out  W  current count (registered).
REQ-012 tick  out  1  prescaler tick; counter advances at the end of this cycle.
REQ-013 running  out  1  high while in state RUN.
REQ-014 done  out  1  one-cycle pulse on terminal count.
REQ-015 err  out  1  one-cycle pulse when an accepted command is illegal in the current state.

Function
REQ-016 The state machine SHALL have the states IDLE, RUN and DONE.
REQ-017 Internal registers SHALL be: base (W bits), limit (W bits), N-bit prescaler pre, latched dir and reload flags.
REQ-018 cmd_ready SHALL be constantly 1 outside reset, so every command completes in one cycle.
REQ-019 LOAD in IDLE/DONE SHALL set base <= cmd_arg and data <= cmd_arg; DONE -> IDLE.
REQ-020 SETLIM in IDLE/DONE SHALL set limit <= cmd_arg; the state is unchanged.
REQ-021 START in IDLE SHALL enter RUN with pre <= 0, latch dir/reload, and leave data unchanged (resume).
REQ-022 START in DONE SHALL enter RUN with pre <= 0, data <= base, and latch dir/reload.
REQ-023 STOP in RUN SHALL enter IDLE with pre <= 0 and data held; STOP in IDLE/DONE SHALL have no effect and raise no err.
REQ-024 START, LOAD or SETLIM in RUN SHALL be consumed with no effect; err SHALL pulse in the following cycle.
REQ-025 In RUN, pre SHALL increment by 1 each cycle, mod 2^N; outside RUN, pre SHALL hold 0.
REQ-026 tick SHALL equal (state == RUN) && (pre == 2^N-1), decoded from registered state.
REQ-027 First tick timing: START accepted at edge k -> first tick in the cycle ending at edge k+2^N, then every 2^N cycles.
REQ-028 Tick with data != limit: data <= data+1 (up) or data-1 (down), wrapping mod 2^W.
REQ-029 Tick with data == limit (either direction): done pulses in the next cycle and data does not step.
  - reload = 1: data <= base; the state stays RUN.
  - reload = 0: the state becomes DONE and data is held.
REQ-030 STOP accepted in the same cycle as tick: STOP SHALL win; no data step and no done.
REQ-031 done and err SHALL be registered; each is high for exactly one cycle per event.
REQ-032 running SHALL be registered and equal to (state == RUN).

Reset
REQ-033 While rst = 1 at an edge, the block SHALL set:
  - state = IDLE, pre = 0, data = 0, base = 0, limit = 2^W-1;
  - dir = up, reload = 0;
  - tick = 0, done = 0, err = 0, running = 0.
REQ-034 rst SHALL take priority over any command or tick in the same cycle, including mid-RUN.
REQ-035 cmd_ready SHALL be 0 during a cycle in which rst = 1.

Verification (N = 2, W = 4; tick every 4 cycles)
REQ-036 LOAD 3, SETLIM 6, START up, reload = 0 -> data steps 3,4,5,6 at ticks 1-3; tick 4 -> done pulse, DONE, running = 0, data = 6.
REQ-037 LOAD 14, SETLIM 15, START up, reload = 1 -> data steps 14,15,14,15; done pulses on each tick seen at data = 15; running stays 1.
REQ-038 LOAD 1, SETLIM 14, START down -> data steps 1,0,15,14 (wrap); next tick -> done, DONE state.
REQ-039 RUN with data = 5; STOP in the same cycle as tick -> data stays 5, IDLE, no done; START -> first tick exactly 4 cycles later, data = 6.
REQ-040 LOAD 9 issued in RUN -> err pulses once; base and data are unaffected; counting continues.
REQ-041 rst asserted mid-RUN with data = 7 -> next cycle: data = 0, running = 0, limit = 15, no done or err.
